// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the instruction fetch unit and its bench.
package riscv_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
    localparam int          PC_STEP_DEFAULT = 4;

endpackage

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch between the PC register, imem and decode.
// Every output is a register; redirects win over everything but reset.
module instr_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int ILEN    = 32,
    parameter int PC_STEP = PC_STEP_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_load,
    output logic [XLEN-1:0] pc_next,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [ILEN-1:0] mem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [ILEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);

    fetch_state_e    state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            pc_load_q, pc_load_d;
    logic [XLEN-1:0] pc_next_q, pc_next_d;
    logic            if_valid_q, if_valid_d;
    logic [ILEN-1:0] if_instr_q, if_instr_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic            drop_q, drop_d;

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        pc_load_d  = 1'b0;
        pc_next_d  = pc_next_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        drop_d     = drop_q;

        unique case (state_q)
            IDLE: begin
                state_d = redirect ? IDLE : ADDR;
            end
            ADDR: begin
                if (redirect) begin
                    state_d = IDLE;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_in;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // The request stays up until acked, even across a redirect.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (drop_q || redirect) begin
                        drop_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        if_instr_d = mem_rdata;
                        if_pc_d    = mem_addr_q;
                        if_valid_d = 1'b1;
                        pc_load_d  = 1'b1;
                        pc_next_d  = mem_addr_q + XLEN'(PC_STEP);
                        state_d    = DELIVER;
                    end
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            DELIVER: begin
                if (redirect) begin
                    if_valid_d = 1'b0;
                    state_d    = IDLE;
                end else if (if_ready) begin
                    if_valid_d = 1'b0;
                    state_d    = ADDR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (redirect) begin
            pc_load_d = 1'b1;
            pc_next_d = redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            pc_load_q  <= 1'b0;
            pc_next_q  <= '0;
            if_valid_q <= 1'b0;
            if_instr_q <= ILEN'(NOP_INSTR);
            if_pc_q    <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            pc_load_q  <= pc_load_d;
            pc_next_q  <= pc_next_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            drop_q     <= drop_d;
        end
    end

    assign pc_load  = pc_load_q;
    assign pc_next  = pc_next_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign if_valid = if_valid_q;
    assign if_instr = if_instr_q;
    assign if_pc    = if_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: PC register and memory models, vector table,
// corner-case sequences and a randomized run against a delivery-order model.
module tb_instr_fetch_unit;
    import riscv_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc_in;
    logic        pc_load;
    logic [63:0] pc_next;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [63:0] if_pc;

    int total = 0;
    int bad   = 0;

    instr_fetch_unit #(.XLEN(64), .ILEN(32), .PC_STEP(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .pc_load     (pc_load),
        .pc_next     (pc_next),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A3C_0F17;
    endfunction

    // PC register model
    logic [63:0] pc_q;
    logic [63:0] pc_rst_val = 64'd0;
    always @(posedge clk) begin
        if (reset)        pc_q <= pc_rst_val;
        else if (pc_load) pc_q <= pc_next;
    end
    assign pc_in = pc_q;

    // Instruction memory: auto responder or manual drive
    bit          auto_mem = 1'b0;
    bit          rand_lat = 1'b0;
    int          fixed_lat = 1;
    int          wcnt = 0;
    int          lat = 1;
    logic        ack_a = 1'b0;
    logic [31:0] rd_a = 32'd0;
    logic        ack_m;
    logic [31:0] rd_m;
    assign mem_ack   = auto_mem ? ack_a : ack_m;
    assign mem_rdata = auto_mem ? rd_a : rd_m;

    always @(negedge clk) begin
        if (mem_req && !reset) begin
            if (wcnt >= lat) begin
                ack_a = 1'b1;
                rd_a  = memf(mem_addr);
                wcnt  = 0;
                lat   = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
            end else begin
                ack_a = 1'b0;
                wcnt++;
            end
        end else begin
            ack_a = 1'b0;
            wcnt  = 0;
            lat   = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_reset(input logic [63:0] rv);
        pc_rst_val  = rv;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 64'd0;
        ack_m       = 1'b0;
        rd_m        = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_req(input string nm);
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {63'd0, mem_req}, 64'd1);
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (if_valid !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {63'd0, if_valid}, 64'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   {63'd0, mem_req},  64'd0);
        chk({tag, "_addr"},  mem_addr,          64'd0);
        chk({tag, "_load"},  {63'd0, pc_load},  64'd0);
        chk({tag, "_next"},  pc_next,           64'd0);
        chk({tag, "_valid"}, {63'd0, if_valid}, 64'd0);
        chk({tag, "_instr"}, {32'd0, if_instr}, {32'd0, NOP_INSTR});
        chk({tag, "_pc"},    if_pc,             64'd0);
    endtask

    typedef struct {
        logic [63:0] start;
        int          lat;
        logic [63:0] nxt;
    } vec_t;

    vec_t        vecs[5];
    bit          seen;
    int          pl;
    int          n;
    int          hs;
    logic [63:0] exp_pc;

    initial begin
        vecs[0] = '{64'd1023,                 1, 64'd1027};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFC,  0, 64'd0};
        vecs[2] = '{64'd3,                    2, 64'd7};
        vecs[3] = '{64'd0,                    1, 64'd4};
        vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFE,  0, 64'h8000_0000_0000_0002};
        if_ready = 1'b1;

        do_reset(64'd1023);
        chk_reset_vals("rst");

        // vector table: single fetch, PC+4 load, next fetch address
        for (int i = 0; i < 5; i++) begin
            do_reset(vecs[i].start);
            auto_mem  = 1'b1;
            rand_lat  = 1'b0;
            fixed_lat = vecs[i].lat;
            if_ready  = 1'b1;
            wait_req("v_req");
            chk("v_addr", mem_addr, vecs[i].start);
            wait_valid("v_valid");
            chk("v_ifpc",  if_pc, vecs[i].start);
            chk("v_instr", {32'd0, if_instr}, {32'd0, memf(vecs[i].start)});
            chk("v_load",  {63'd0, pc_load}, 64'd1);
            chk("v_next",  pc_next, vecs[i].nxt);
            @(negedge clk);
            wait_req("v_req2");
            chk("v_addr2", mem_addr, vecs[i].nxt);
        end

        // decode stall holds the word and blocks new requests
        do_reset(64'h100);
        auto_mem  = 1'b1;
        fixed_lat = 1;
        if_ready  = 1'b0;
        wait_valid("st_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("st_hold_v",  {63'd0, if_valid}, 64'd1);
            chk("st_hold_pc", if_pc, 64'h100);
            chk("st_hold_i",  {32'd0, if_instr}, {32'd0, memf(64'h100)});
            chk("st_noreq",   {63'd0, mem_req}, 64'd0);
        end
        if_ready = 1'b1;
        @(negedge clk);
        chk("st_drop_v", {63'd0, if_valid}, 64'd0);
        chk("st_req_lo", {63'd0, mem_req}, 64'd0);
        @(negedge clk);
        chk("st_resume", {63'd0, mem_req}, 64'd1);
        chk("st_addr",   mem_addr, 64'h104);

        // redirect while waiting, ack three cycles later
        do_reset(64'h40);
        auto_mem = 1'b0;
        if_ready = 1'b1;
        wait_req("rw_req");
        chk("rw_addr", mem_addr, 64'h40);
        redirect    = 1'b1;
        redirect_pc = 64'h2000;
        @(negedge clk);
        redirect = 1'b0;
        chk("rw_load",  {63'd0, pc_load}, 64'd1);
        chk("rw_next",  pc_next, 64'h2000);
        chk("rw_hold",  {63'd0, mem_req}, 64'd1);
        chk("rw_haddr", mem_addr, 64'h40);
        repeat (2) @(negedge clk);
        ack_m = 1'b1;
        rd_m  = 32'hDEAD_BEEF;
        @(negedge clk);
        ack_m = 1'b0;
        chk("rw_reqlo", {63'd0, mem_req}, 64'd0);
        seen = if_valid;
        n = 0;
        while (!mem_req && n < 30) begin
            @(negedge clk);
            seen |= if_valid;
            n++;
        end
        chk("rw_req2",  {63'd0, mem_req}, 64'd1);
        chk("rw_novld", {63'd0, seen}, 64'd0);
        chk("rw_addr2", mem_addr, 64'h2000);
        ack_m = 1'b1;
        rd_m  = memf(64'h2000);
        @(negedge clk);
        ack_m = 1'b0;
        chk("rw_dv",   {63'd0, if_valid}, 64'd1);
        chk("rw_dpc",  if_pc, 64'h2000);
        chk("rw_di",   {32'd0, if_instr}, {32'd0, memf(64'h2000)});
        chk("rw_dnxt", pc_next, 64'h2004);

        // redirect on the same edge as the ack
        do_reset(64'h80);
        auto_mem = 1'b0;
        wait_req("ra_req");
        redirect    = 1'b1;
        redirect_pc = 64'h2000;
        ack_m       = 1'b1;
        rd_m        = 32'h1234_5678;
        @(negedge clk);
        redirect = 1'b0;
        ack_m    = 1'b0;
        chk("ra_load", {63'd0, pc_load}, 64'd1);
        chk("ra_next", pc_next, 64'h2000);
        chk("ra_req0", {63'd0, mem_req}, 64'd0);
        chk("ra_vld0", {63'd0, if_valid}, 64'd0);
        seen = 1'b0;
        pl = 0;
        n = 0;
        while (!mem_req && n < 30) begin
            @(negedge clk);
            seen |= if_valid;
            if (pc_load) pl++;
            n++;
        end
        chk("ra_req2",  {63'd0, mem_req}, 64'd1);
        chk("ra_novld", {63'd0, seen}, 64'd0);
        chk("ra_nold",  64'(pl), 64'd0);
        chk("ra_addr2", mem_addr, 64'h2000);

        // reset in WAIT, then a spurious ack while idle
        do_reset(64'h300);
        auto_mem = 1'b0;
        wait_req("rs_req");
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("rs");
        reset = 1'b0;
        ack_m = 1'b1;
        rd_m  = 32'hBAD0_BAD0;
        @(negedge clk);
        ack_m = 1'b0;
        chk("rs_vld",  {63'd0, if_valid}, 64'd0);
        chk("rs_req",  {63'd0, mem_req}, 64'd0);
        chk("rs_ins",  {32'd0, if_instr}, {32'd0, NOP_INSTR});
        seen = 1'b0;
        n = 0;
        while (!mem_req && n < 30) begin
            @(negedge clk);
            seen |= if_valid;
            n++;
        end
        chk("rs_req2", {63'd0, mem_req}, 64'd1);
        chk("rs_addr", mem_addr, 64'h300);
        repeat (3) begin
            @(negedge clk);
            seen |= if_valid;
        end
        chk("rs_novld", {63'd0, seen}, 64'd0);

        // randomized run: delivered stream must follow PC+4 and redirects
        do_reset(64'h1000);
        auto_mem = 1'b1;
        rand_lat = 1'b1;
        exp_pc   = 64'h1000;
        hs       = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 19) == 0);
            redirect_pc = {$urandom, $urandom};
            if ($urandom_range(0, 7) != 0) redirect_pc[1:0] = 2'b00;
            if (if_valid && if_ready) begin
                chk("rnd_pc",  if_pc, exp_pc);
                chk("rnd_ins", {32'd0, if_instr}, {32'd0, memf(if_pc)});
                exp_pc = exp_pc + 64'd4;
                hs++;
            end
            if (redirect) exp_pc = redirect_pc;
        end
        @(negedge clk);
        redirect = 1'b0;
        if_ready = 1'b0;
        chk("rnd_hs", {63'd0, hs >= 100}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
